// File: rtl/keypad_entry_ctrl.sv
// ============================================================================
//  Module   : keypad_entry_ctrl
//  Purpose  : Microwave-style keypad entry controller. It synchronizes and
//             debounces encoder keys, builds a 4-digit BCD preset and
//             sequences the load/run handshake with the countdown timer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_entry_ctrl #(
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [3:0]  BCD_in,
    input  logic        start,
    input  logic        clear,
    input  logic        door_closed,
    input  logic        timer_done,
    output logic        enablen,
    output logic [15:0] digits,
    output logic [2:0]  entry_count,
    output logic        load,
    output logic        running,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_REL = 2'd1,
        S_LOAD     = 2'd2,
        S_RUN      = 2'd3
    } state_t;

    localparam logic [3:0] c_accept_cnt = 4'(DEBOUNCE - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_valid_m;
    logic        r_valid_s;
    logic [3:0]  r_bcd_m;
    logic [3:0]  r_bcd_s;
    logic [3:0]  r_bcd_prev;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_start_d;
    logic        r_lock;
    logic [15:0] r_digits;
    logic [15:0] w_digits_nxt;
    logic [2:0]  r_count;
    logic [2:0]  w_count_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic        w_start_rise;
    logic        w_start_ok;
    logic        w_key_ok;

    assign w_start_rise = start & ~r_start_d;
    assign w_start_ok   = (r_count != 3'd0) && door_closed && (r_digits[7:4] <= 4'd5);

    // A key still held from before RUN stays locked out until it is released.
    assign w_key_ok = (r_state == S_IDLE) && !r_valid_s && !r_lock &&
                      (r_bcd_s <= 4'd9) && (w_cnt_nxt == c_accept_cnt);

    always_comb begin
        w_cnt_nxt = 4'd0;
        if (r_state != S_RUN && !r_valid_s && r_bcd_s == r_bcd_prev) begin
            w_cnt_nxt = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_m  <= 1'b1;
            r_valid_s  <= 1'b1;
            r_bcd_m    <= 4'hF;
            r_bcd_s    <= 4'hF;
            r_bcd_prev <= 4'hF;
            r_cnt      <= 4'd0;
            r_start_d  <= 1'b0;
            r_lock     <= 1'b0;
            r_state    <= S_IDLE;
            r_digits   <= 16'h0000;
            r_count    <= 3'd0;
            r_err      <= 1'b0;
        end else begin
            r_valid_m  <= valid;
            r_valid_s  <= r_valid_m;
            r_bcd_m    <= BCD_in;
            r_bcd_s    <= r_bcd_m;
            r_bcd_prev <= r_bcd_s;
            r_cnt      <= w_cnt_nxt;
            r_start_d  <= start;
            if (r_state == S_LOAD || r_state == S_RUN) begin
                r_lock <= 1'b1;
            end else if (r_valid_s) begin
                r_lock <= 1'b0;
            end
            r_state    <= w_state_nxt;
            r_digits   <= w_digits_nxt;
            r_count    <= w_count_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Priority within entry states: clear, then start edge, then key, then release.
    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        w_count_nxt  = r_count;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE, S_WAIT_REL: begin
                if (clear) begin
                    w_state_nxt  = S_IDLE;
                    w_digits_nxt = 16'h0000;
                    w_count_nxt  = 3'd0;
                end else if (w_start_rise) begin
                    if (w_start_ok) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_key_ok) begin
                    w_state_nxt = S_WAIT_REL;
                    if (r_count < 3'd4) begin
                        w_digits_nxt = {r_digits[11:0], r_bcd_s};
                        w_count_nxt  = r_count + 3'd1;
                    end
                end else if (r_state == S_WAIT_REL && r_valid_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (timer_done || clear || !door_closed) begin
                    w_state_nxt  = S_IDLE;
                    w_digits_nxt = 16'h0000;
                    w_count_nxt  = 3'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign enablen     = !(r_state == S_IDLE || r_state == S_WAIT_REL);
    assign load        = (r_state == S_LOAD);
    assign running     = (r_state == S_RUN);
    assign err         = r_err;
    assign digits      = r_digits;
    assign entry_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
// ============================================================================
//  Module   : tb_keypad_entry_ctrl
//  Purpose  : Self-checking bench for keypad_entry_ctrl (DEBOUNCE = 4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_entry_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [3:0]  BCD_in;
    logic        start;
    logic        clear;
    logic        door_closed;
    logic        timer_done;
    logic        enablen;
    logic [15:0] digits;
    logic [2:0]  entry_count;
    logic        load;
    logic        running;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_digits;
    logic [2:0]  m_count;
    logic [18:0] exp_q[$];
    logic [18:0] e;

    keypad_entry_ctrl #(.DEBOUNCE(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .BCD_in      (BCD_in),
        .start       (start),
        .clear       (clear),
        .door_closed (door_closed),
        .timer_done  (timer_done),
        .enablen     (enablen),
        .digits      (digits),
        .entry_count (entry_count),
        .load        (load),
        .running     (running),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear();
        m_digits = 16'h0000;
        m_count  = 3'd0;
    endtask

    // Drives one key press and pushes the model's expected {count,digits}.
    task automatic press(input logic [3:0] key, input int hold, input int gap, input bit accept);
        valid  = 1'b0;
        BCD_in = key;
        tick(hold);
        valid  = 1'b1;
        BCD_in = 4'hF;
        tick(gap);
        if (accept && key <= 4'd9 && m_count < 3'd4) begin
            m_digits = {m_digits[11:0], key};
            m_count  = m_count + 3'd1;
        end
        exp_q.push_back({m_count, m_digits});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 1'b1; BCD_in = 4'hF; start = 1'b0; clear = 1'b0;
        door_closed = 1'b1; timer_done = 1'b0;
        model_clear();
        tick(2);
        vectors++;
        if ({digits, entry_count, enablen, load, running, err} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_state: got d=%h c=%0d en=%b ld=%b run=%b err=%b, want all zero",
                     digits, entry_count, enablen, load, running, err);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_entry();
        logic [3:0] keys [4] = '{4'd1, 4'd2, 4'd3, 4'd0};
        for (int i = 0; i < 4; i++) begin
            press(keys[i], 10, 5, 1'b1);
            e = exp_q.pop_front();
            vectors++;
            if ({entry_count, digits} !== e) begin
                miscompares++;
                $display("FAIL entry_key%0d: got c=%0d d=%h, want c=%0d d=%h",
                         i, entry_count, digits, e[18:16], e[15:0]);
            end
        end
    endtask

    task automatic test_fifth_and_start();
        press(4'd7, 10, 5, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if ({entry_count, digits} !== e || e !== {3'd4, 16'h1230}) begin
            miscompares++;
            $display("FAIL fifth_digit: got c=%0d d=%h, want c=4 d=1230", entry_count, digits);
        end
        start = 1'b1;
        tick();
        vectors++;
        if ({load, running, enablen} !== 3'b101) begin
            miscompares++;
            $display("FAIL start_load: got ld=%b run=%b en=%b, want 1 0 1", load, running, enablen);
        end
        start = 1'b0;
        tick();
        vectors++;
        if ({load, running, enablen} !== 3'b011) begin
            miscompares++;
            $display("FAIL start_run: got ld=%b run=%b en=%b, want 0 1 1", load, running, enablen);
        end
    endtask

    task automatic test_timer_done();
        valid = 1'b0; BCD_in = 4'd4;
        tick(10);
        vectors++;
        if (running !== 1'b1 || digits !== 16'h1230) begin
            miscompares++;
            $display("FAIL run_key_ignored: got run=%b d=%h, want 1 1230", running, digits);
        end
        timer_done = 1'b1;
        tick();
        timer_done = 1'b0;
        model_clear();
        vectors++;
        if ({running, enablen} !== 2'b00 || {entry_count, digits} !== 19'd0) begin
            miscompares++;
            $display("FAIL timer_done: got run=%b en=%b c=%0d d=%h, want 0 0 0 0000",
                     running, enablen, entry_count, digits);
        end
        tick(10);
        vectors++;
        if ({entry_count, digits} !== 19'd0) begin
            miscompares++;
            $display("FAIL held_key_after_run: got c=%0d d=%h, want 0 0000", entry_count, digits);
        end
        valid = 1'b1; BCD_in = 4'hF;
        tick(5);
        press(4'd4, 10, 5, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if ({entry_count, digits} !== e) begin
            miscompares++;
            $display("FAIL new_press_after_run: got c=%0d d=%h, want c=%0d d=%h",
                     entry_count, digits, e[18:16], e[15:0]);
        end
    endtask

    task automatic test_glitch();
        do_clear();
        press(4'd5, 3, 5, 1'b0);
        e = exp_q.pop_front();
        vectors++;
        if ({entry_count, digits} !== e) begin
            miscompares++;
            $display("FAIL glitch_3cyc: got c=%0d d=%h, want c=%0d d=%h",
                     entry_count, digits, e[18:16], e[15:0]);
        end
        valid = 1'b0; BCD_in = 4'd5;
        tick(4);
        valid = 1'b1; BCD_in = 4'hF;
        tick();
        vectors++;
        if (digits !== 16'h0000) begin
            miscompares++;
            $display("FAIL latency_edge5: got d=%h, want 0000", digits);
        end
        tick();
        m_digits = 16'h0005; m_count = 3'd1;
        exp_q.push_back({m_count, m_digits});
        e = exp_q.pop_front();
        vectors++;
        if ({entry_count, digits} !== e) begin
            miscompares++;
            $display("FAIL latency_edge6: got c=%0d d=%h, want c=%0d d=%h",
                     entry_count, digits, e[18:16], e[15:0]);
        end
        tick(5);
    endtask

    task automatic test_err();
        logic [3:0] keys [4] = '{4'd0, 4'd0, 4'd7, 4'd0};
        do_clear();
        for (int i = 0; i < 4; i++) begin
            press(keys[i], 10, 5, 1'b1);
            e = exp_q.pop_front();
            vectors++;
            if ({entry_count, digits} !== e) begin
                miscompares++;
                $display("FAIL err_entry%0d: got c=%0d d=%h, want c=%0d d=%h",
                         i, entry_count, digits, e[18:16], e[15:0]);
            end
        end
        start = 1'b1;
        tick();
        vectors++;
        if ({err, load} !== 2'b10) begin
            miscompares++;
            $display("FAIL err_sec_tens: got err=%b ld=%b, want 1 0", err, load);
        end
        tick();
        vectors++;
        if ({err, load, enablen} !== 3'b000) begin
            miscompares++;
            $display("FAIL err_pulse_width: got err=%b ld=%b en=%b, want 0 0 0", err, load, enablen);
        end
        tick();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_no_refire: got err=%b, want 0", err);
        end
        start = 1'b0;
        tick();
        do_clear();
        press(4'd1, 10, 5, 1'b1);
        void'(exp_q.pop_front());
        door_closed = 1'b0;
        start = 1'b1;
        tick();
        vectors++;
        if ({err, load} !== 2'b10) begin
            miscompares++;
            $display("FAIL err_door_open: got err=%b ld=%b, want 1 0", err, load);
        end
        start = 1'b0;
        tick();
        vectors++;
        if ({err, load, enablen} !== 3'b000) begin
            miscompares++;
            $display("FAIL err_door_after: got err=%b ld=%b en=%b, want 0 0 0", err, load, enablen);
        end
        door_closed = 1'b1;
    endtask

    task automatic test_clear_start();
        logic [3:0] keys [3] = '{4'd1, 4'd0, 4'd0};
        do_clear();
        for (int i = 0; i < 3; i++) press(keys[i], 10, 5, 1'b1);
        for (int i = 0; i < 3; i++) e = exp_q.pop_front();
        vectors++;
        if ({entry_count, digits} !== e) begin
            miscompares++;
            $display("FAIL cs_entry: got c=%0d d=%h, want c=%0d d=%h",
                     entry_count, digits, e[18:16], e[15:0]);
        end
        clear = 1'b1; start = 1'b1;
        tick();
        model_clear();
        vectors++;
        if ({entry_count, digits} !== 19'd0 || load !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_beats_start: got c=%0d d=%h ld=%b, want 0 0000 0",
                     entry_count, digits, load);
        end
        clear = 1'b0; start = 1'b0;
        tick();
        vectors++;
        if ({load, enablen, err} !== 3'b000) begin
            miscompares++;
            $display("FAIL clear_start_after: got ld=%b en=%b err=%b, want 0 0 0", load, enablen, err);
        end
    endtask

    task automatic test_back_to_back();
        press(4'd1, 10, 5, 1'b1);
        press(4'd5, 10, 5, 1'b1);
        void'(exp_q.pop_front());
        e = exp_q.pop_front();
        vectors++;
        if ({entry_count, digits} !== e) begin
            miscompares++;
            $display("FAIL b2b_entry: got c=%0d d=%h, want c=%0d d=%h",
                     entry_count, digits, e[18:16], e[15:0]);
        end
        start = 1'b1; tick(); start = 1'b0; tick();
        door_closed = 1'b0;
        tick();
        model_clear();
        vectors++;
        if ({running, enablen} !== 2'b00 || {entry_count, digits} !== 19'd0) begin
            miscompares++;
            $display("FAIL door_abort: got run=%b en=%b c=%0d d=%h, want 0 0 0 0000",
                     running, enablen, entry_count, digits);
        end
        door_closed = 1'b1;
        tick();
        press(4'd2, 10, 5, 1'b1);
        void'(exp_q.pop_front());
        start = 1'b1; tick(); start = 1'b0; tick();
        vectors++;
        if (running !== 1'b1) begin
            miscompares++;
            $display("FAIL rerun: got run=%b, want 1", running);
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({digits, entry_count, enablen, load, running, err} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_in_run: got d=%h c=%0d en=%b ld=%b run=%b err=%b, want all zero",
                     digits, entry_count, enablen, load, running, err);
        end
        tick();
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_entry();
        test_fifth_and_start();
        test_timer_done();
        test_glitch();
        test_err();
        test_clear_start();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 4, consecutive stable synced cycles needed to accept a key (legal range 1..15).
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid  input  1  from keypad encoder, active-low: 0 = key pressed.
REQ-005 BCD_in  input  4  encoder digit code; 4'b1111 = no key.
REQ-006 start  input  1  level, active-high start request.
REQ-007 clear  input  1  level, active-high clear/abort request.
REQ-008 door_closed  input  1  1 = door closed, cooking allowed.
REQ-009 timer_done  input  1  1-cycle pulse from countdown timer at zero.
REQ-010 enablen  output  1  encoder enable, active-low; 0 only in IDLE and WAIT_REL.
REQ-011 digits  output  16  preset time {min_tens, min_units, sec_tens, sec_units}, BCD.
REQ-012 entry_count  output  3  number of digits entered, 0..4.
REQ-013 load  output  1  1-cycle pulse: timer shall capture digits.
REQ-014 running  output  1  high in RUN state.
REQ-015 err  output  1  1-cycle pulse on rejected start.

Function
REQ-016 valid and BCD_in shall pass through a 2-flop synchronizer (valid_s, bcd_s) before any use.
REQ-017 States: IDLE, WAIT_REL, LOAD, RUN; encoding implementer's choice.
REQ-018 Debounce counter: increments when valid_s=0 and bcd_s equals its previous-cycle value; clears otherwise; saturates, never wraps.
REQ-019 Key accepted in IDLE on the cycle the counter reaches DEBOUNCE-1 with bcd_s<=9; bcd_s>9 never accepted.
REQ-020 On acceptance with entry_count<4: digits <= {digits[11:0], bcd_s}, entry_count+1; with entry_count=4: digits unchanged, no increment.
REQ-021 Every acceptance (including ignored 5th digit) moves IDLE -> WAIT_REL.
REQ-022 WAIT_REL -> IDLE on first cycle valid_s=1; no further acceptance while in WAIT_REL.
REQ-023 Latency: stable press at input from cycle 0 -> digits updated at edge 2+DEBOUNCE.
REQ-024 start in IDLE/WAIT_REL with entry_count>0, door_closed=1, digits[7:4]<=5 -> LOAD.
REQ-025 start failing any REQ-024 condition -> err pulse 1 cycle, state unchanged; err re-fires only after start deasserts and reasserts.
REQ-026 start is edge-sensitive: acted on only in cycle after start low->high (registered previous value).
REQ-027 LOAD: load=1 for exactly one cycle, enablen=1, then RUN unconditionally.
REQ-028 RUN: enablen=1, running=1, keys ignored, debounce counter held at 0.
REQ-029 RUN + timer_done -> IDLE, digits=0, entry_count=0.
REQ-030 RUN + clear, or RUN + door_closed=0 -> IDLE, digits/entry_count cleared (abort).
REQ-031 clear in IDLE/WAIT_REL: digits=0, entry_count=0, state IDLE.
REQ-032 Simultaneous events priority: clear > start > key acceptance; accepted key in same cycle as valid start is discarded.
REQ-033 Simultaneous timer_done and clear in RUN: single transition to IDLE, cleared.

Reset
REQ-034 reset=1 asynchronously forces: state IDLE, digits=16'h0000, entry_count=0, load=0, running=0, err=0, enablen=0, synchronizers to valid_s=1/bcd_s=4'b1111, debounce counter=0, start history=0.
REQ-035 Reset mid-RUN shall drop running and enablen low immediately, without load pulse.

Verification (DEBOUNCE=4)
REQ-036 Press 1,2,3,0 each held 10 cycles with 5-cycle gaps -> digits=16'h1230, entry_count=4.
REQ-037 Fifth press 7 after REQ-036 -> digits stays 16'h1230; then start, door_closed=1 -> load 1 cycle, running=1.
REQ-038 Key 5 glitch held 3 cycles -> no change; held 4 cycles -> digits=16'h0005 at edge 6 after press.
REQ-039 Digits 16'h0070 (sec_tens=7) + start -> err 1 cycle, no load; door_closed=0 + start -> err, no load.
REQ-040 In RUN, timer_done -> IDLE, digits=0, enablen=0; key held in RUN ignored, accepted only after new press in IDLE.
REQ-041 clear and start same cycle with digits=16'h0100 -> digits=0, no load; reset asserted in RUN -> all REQ-034 values immediately.
